// File: rtl/reset_sequencer_pkg.sv
// Shared types and default sizing for the reset sequencer.
// RST_SEQ_TIMEOUT_EN adds the ERROR state used by the per-stage ready timeout.
package reset_sequencer_pkg;

  localparam int DEF_STAGES         = 3;
  localparam int DEF_HOLD_CYCLES    = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_WAIT,
    ST_GAP,
    ST_DONE
`ifdef RST_SEQ_TIMEOUT_EN
    , ST_ERROR
`endif
  } seq_state_t;

  // A single-stage build still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_synchroniser.sv
// Reset synchroniser: asserts together with async_reset, releases on the second clk edge after it drops.
module reset_synchroniser (
  input  logic clk,
  input  logic async_reset,
  output logic sync_reset
);

  logic meta;

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      meta       <= 1'b1;
      sync_reset <= 1'b1;
    end else begin
      meta       <= 1'b0;
      sync_reset <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Releases STAGES reset domains in index order, each after a hold gap and the previous stage's ready.
// Build option RST_SEQ_TIMEOUT_EN: per-stage ready timeout with a sticky timeout_err and ERROR state.
//   state  | meaning
//   ASSERT | all resets held, counting the initial hold
//   WAIT   | stage active_stage released, waiting for its ready
//   GAP    | counting the gap before releasing the next stage
//   DONE   | every stage released and acknowledged
//   ERROR  | ready timeout, all resets re-held until a restart
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int STAGES         = DEF_STAGES,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                           clk,
  input  logic                           async_reset,
  input  logic                           sw_reset_req,
  input  logic [STAGES-1:0]              stage_ready,
  output logic [STAGES-1:0]              stage_reset,
  output logic [idx_width(STAGES)-1:0]   active_stage,
  output logic                           seq_busy,
  output logic                           seq_done,
  output logic                           timeout_err
);

  localparam int AW       = idx_width(STAGES);
  localparam int CNT_MAX  = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
  localparam int CW       = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [AW-1:0] LAST_STAGE = AW'(STAGES - 1);
`ifdef RST_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
`endif

  logic          rst;
  seq_state_t    state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] next_stage;

  reset_synchroniser u_sync (
    .clk         (clk),
    .async_reset (async_reset),
    .sync_reset  (rst)
  );

  assign next_stage = active_stage + 1'b1;

`ifndef RST_SEQ_TIMEOUT_EN
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_ASSERT;
      cnt          <= '0;
      stage_reset  <= '1;
      active_stage <= '0;
      seq_busy     <= 1'b1;
      seq_done     <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
      timeout_err  <= 1'b0;
`endif
    end else if (sw_reset_req) begin
      // A soft restart outranks any ready or terminal count seen on the same edge.
      state        <= ST_ASSERT;
      cnt          <= '0;
      stage_reset  <= '1;
      active_stage <= '0;
      seq_busy     <= 1'b1;
      seq_done     <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
      timeout_err  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_ASSERT: begin
          if (cnt == HOLD_LAST) begin
            cnt            <= '0;
            stage_reset[0] <= 1'b0;
            active_stage   <= '0;
            state          <= ST_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (stage_ready[active_stage]) begin
            cnt <= '0;
            if (active_stage == LAST_STAGE) begin
              state    <= ST_DONE;
              seq_busy <= 1'b0;
              seq_done <= 1'b1;
            end else begin
              state <= ST_GAP;
            end
          end
`ifdef RST_SEQ_TIMEOUT_EN
          else if (cnt == TIMEOUT_LAST) begin
            cnt         <= '0;
            stage_reset <= '1;
            timeout_err <= 1'b1;
            state       <= ST_ERROR;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        ST_GAP: begin
          if (cnt == HOLD_LAST) begin
            cnt                     <= '0;
            active_stage            <= next_stage;
            stage_reset[next_stage] <= 1'b0;
            state                   <= ST_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
        end
`ifdef RST_SEQ_TIMEOUT_EN
        ST_ERROR: begin
          stage_reset <= '1;
        end
`endif
        default: begin
          state        <= ST_ASSERT;
          cnt          <= '0;
          stage_reset  <= '1;
          active_stage <= '0;
          seq_busy     <= 1'b1;
          seq_done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: expected output words are queued per step and popped at each sample point.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       async_reset;
  logic       sw_reset_req;
  logic [2:0] stage_ready;
  logic [2:0] stage_reset;
  logic [1:0] active_stage;
  logic       seq_busy;
  logic       seq_done;
  logic       timeout_err;

  reset_sequencer dut (
    .clk          (clk),
    .async_reset  (async_reset),
    .sw_reset_req (sw_reset_req),
    .stage_ready  (stage_ready),
    .stage_reset  (stage_reset),
    .active_stage (active_stage),
    .seq_busy     (seq_busy),
    .seq_done     (seq_done),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] obs;

  // Packed as {stage_reset, active_stage, seq_busy, seq_done, timeout_err}.
  assign obs = {stage_reset, active_stage, seq_busy, seq_done, timeout_err};

  function automatic logic [7:0] pk(input logic [2:0] rs, input logic [1:0] as,
                                    input logic b, input logic d, input logic t);
    return {rs, as, b, d, t};
  endfunction

  task automatic push(input string tag, input logic [7:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check();
    exp_t x;
    total++;
    assert (sb.size() != 0) else begin
      bad++;
      $error("FAIL scoreboard_underflow observed=%b", obs);
    end
    if (sb.size() != 0) begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        bad++;
        $error("FAIL %s observed=%b expected=%b (rst,act,busy,done,terr)", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sw_pulse();
    sw_reset_req = 1'b1;
    cyc(1);
    sw_reset_req = 1'b0;
  endtask

  initial begin
    async_reset  = 1'b1;
    sw_reset_req = 1'b0;
    stage_ready  = 3'b111;
    cyc(3);
    push("reset_values", pk(3'b111, 2'd0, 1'b1, 1'b0, 1'b0)); check();

    // Full sequence with every ready tied high.
    async_reset = 1'b0;
    push("hold0_edge17", pk(3'b111, 2'd0, 1, 0, 0)); cyc(17); check();
    push("rel0_edge18",  pk(3'b110, 2'd0, 1, 0, 0)); cyc(1);  check();
    push("gap1_edge34",  pk(3'b110, 2'd0, 1, 0, 0)); cyc(16); check();
    push("rel1_edge35",  pk(3'b100, 2'd1, 1, 0, 0)); cyc(1);  check();
    push("gap2_edge51",  pk(3'b100, 2'd1, 1, 0, 0)); cyc(16); check();
    push("rel2_edge52",  pk(3'b000, 2'd2, 1, 0, 0)); cyc(1);  check();
    push("done_edge53",  pk(3'b000, 2'd2, 0, 1, 0)); cyc(1);  check();
    stage_ready = 3'b000;
    push("ready_drop_ignored", pk(3'b000, 2'd2, 0, 1, 0)); cyc(10); check();

    // Stage 2 ready early: must still go last and only after stage 1 acknowledges.
    stage_ready = 3'b100;
    sw_pulse();
    push("sw_from_done",     pk(3'b111, 2'd0, 1, 0, 0)); check();
    push("early_hold",       pk(3'b111, 2'd0, 1, 0, 0)); cyc(15); check();
    push("early_rel0",       pk(3'b110, 2'd0, 1, 0, 0)); cyc(1);  check();
    push("early_wait0",      pk(3'b110, 2'd0, 1, 0, 0)); cyc(20); check();
    stage_ready = 3'b101;
    push("early_gap1",       pk(3'b110, 2'd0, 1, 0, 0)); cyc(16); check();
    push("early_rel1",       pk(3'b100, 2'd1, 1, 0, 0)); cyc(1);  check();
    push("early_wait1",      pk(3'b100, 2'd1, 1, 0, 0)); cyc(20); check();
    stage_ready = 3'b110;
    push("early_gap2",       pk(3'b100, 2'd1, 1, 0, 0)); cyc(16); check();
    push("early_rel2",       pk(3'b000, 2'd2, 1, 0, 0)); cyc(1);  check();
    push("early_done",       pk(3'b000, 2'd2, 0, 1, 0)); cyc(1);  check();

    // Soft restart in GAP, then a soft restart landing on the GAP terminal count.
    stage_ready = 3'b111;
    sw_pulse();
    push("sw_restart",       pk(3'b111, 2'd0, 1, 0, 0)); check();
    push("sw_rel0",          pk(3'b110, 2'd0, 1, 0, 0)); cyc(16); check();
    push("in_gap",           pk(3'b110, 2'd0, 1, 0, 0)); cyc(5);  check();
    sw_pulse();
    push("sw_in_gap",        pk(3'b111, 2'd0, 1, 0, 0)); check();
    push("sw_in_gap_rel0",   pk(3'b110, 2'd0, 1, 0, 0)); cyc(16); check();
    push("gap_before_tc",    pk(3'b110, 2'd0, 1, 0, 0)); cyc(16); check();
    sw_pulse();
    push("sw_beats_tc",      pk(3'b111, 2'd0, 1, 0, 0)); check();

    // Hardware reset while waiting on stage 0, then a complete replay.
    stage_ready = 3'b000;
    push("wait0_again",      pk(3'b110, 2'd0, 1, 0, 0)); cyc(16); check();
    push("wait0_held",       pk(3'b110, 2'd0, 1, 0, 0)); cyc(5);  check();
    #2 async_reset = 1'b1;
    #1;
    push("async_no_edge",    pk(3'b111, 2'd0, 1, 0, 0)); check();
    cyc(2);
    stage_ready = 3'b111;
    async_reset = 1'b0;
    push("replay_hold",      pk(3'b111, 2'd0, 1, 0, 0)); cyc(17); check();
    push("replay_rel0",      pk(3'b110, 2'd0, 1, 0, 0)); cyc(1);  check();
    push("replay_rel1",      pk(3'b100, 2'd1, 1, 0, 0)); cyc(17); check();
    push("replay_rel2",      pk(3'b000, 2'd2, 1, 0, 0)); cyc(17); check();
    push("replay_done",      pk(3'b000, 2'd2, 0, 1, 0)); cyc(1);  check();

    // Stage 1 never acknowledges.
    stage_ready = 3'b101;
    sw_pulse();
    push("to_restart",       pk(3'b111, 2'd0, 1, 0, 0)); check();
    push("to_rel0",          pk(3'b110, 2'd0, 1, 0, 0)); cyc(16); check();
    push("to_rel1",          pk(3'b100, 2'd1, 1, 0, 0)); cyc(17); check();
`ifdef RST_SEQ_TIMEOUT_EN
    push("to_edge1023",      pk(3'b100, 2'd1, 1, 0, 0)); cyc(1023); check();
    push("to_edge1024",      pk(3'b111, 2'd1, 1, 0, 1)); cyc(1);    check();
    stage_ready = 3'b111;
    push("to_sticky",        pk(3'b111, 2'd1, 1, 0, 1)); cyc(10);   check();
    sw_pulse();
    push("to_cleared",       pk(3'b111, 2'd0, 1, 0, 0)); check();
`else
    push("no_timeout",       pk(3'b100, 2'd1, 1, 0, 0)); cyc(1100); check();
    sw_pulse();
    push("no_timeout_sw",    pk(3'b111, 2'd0, 1, 0, 0)); check();
`endif

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter STAGES, default 3: number of sequenced reset domains (PRBS generator, link, error checker).
REQ-002 Parameter HOLD_CYCLES, default 16: reset hold and inter-stage gap, in clk cycles; legal range is 1 or more.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: ready wait limit per stage; legal range is 2 or more.
REQ-004 clk  input  1  single clock; all logic is on its rising edge.
REQ-005 async_reset  input  1  reset, asynchronous, active-high.
REQ-006 sw_reset_req  input  1  single-cycle soft request to restart the whole sequence.
REQ-007 stage_ready  input  STAGES  per-stage acknowledge that the domain is up after its reset is released.
REQ-008 stage_reset  output  STAGES  registered per-stage reset, active-high.
REQ-009 active_stage  output  clog2(STAGES)  index of the stage currently being released or awaited.
REQ-010 seq_busy  output  1  high whenever the block is not in DONE.
REQ-011 seq_done  output  1  high in DONE only.
REQ-012 timeout_err  output  1  sticky stage-timeout flag.

Function
REQ-013 FSM states SHALL be: ASSERT, WAIT, GAP, DONE and ERROR.
REQ-014 ASSERT SHALL drive all stage_reset bits high and count HOLD_CYCLES cycles; on the last count it SHALL clear stage_reset[0], set active_stage=0 and enter WAIT, all on the same edge.
REQ-015 WAIT SHALL sample only stage_ready[active_stage]; ready bits of other stages SHALL be ignored.
REQ-016 When that ready is high in WAIT and active_stage<STAGES-1, the FSM SHALL enter GAP and clear the counter.
REQ-017 When that ready is high in WAIT and active_stage=STAGES-1, the FSM SHALL enter DONE, with seq_done=1 on the next edge.
REQ-018 GAP SHALL count HOLD_CYCLES cycles, then increment active_stage, clear the new stage's stage_reset bit and re-enter WAIT.
REQ-019 Stages SHALL be released strictly in index order, and no released stage SHALL be re-asserted except by sw_reset_req or async_reset.
REQ-020 A ready that drops after its stage was acknowledged SHALL be ignored.
REQ-021 sw_reset_req in any state SHALL set all stage_reset bits high, clear active_stage and the counter, clear timeout_err and enter ASSERT on the next edge.
REQ-022 If sw_reset_req coincides with a ready or a counter terminal count, sw_reset_req SHALL take priority.
REQ-023 The counter width SHALL be clog2(max(HOLD_CYCLES, TIMEOUT_CYCLES)+1), and the counter SHALL never wrap.

Reset
REQ-024 async_reset SHALL clear the FSM flops asynchronously, with deassertion synchronised through a two-flop stage (2-cycle release latency).
REQ-025 Reset values SHALL be: stage_reset=all ones, active_stage=0, seq_busy=1, seq_done=0, timeout_err=0, state=ASSERT, counter=0.
REQ-026 async_reset asserted mid-sequence SHALL return every output to its reset value immediately, without waiting for a clock edge.

Configuration
REQ-027 With RST_SEQ_TIMEOUT_EN defined, WAIT SHALL count cycles since release; at TIMEOUT_CYCLES with ready still low it SHALL enter ERROR.
REQ-028 ERROR SHALL set timeout_err=1, drive all stage_reset bits high, keep seq_busy=1 and be exited only by sw_reset_req or async_reset.
REQ-029 Without RST_SEQ_TIMEOUT_EN, WAIT SHALL wait indefinitely, the ERROR state SHALL be absent and timeout_err SHALL be tied 0 with the port retained.

Structure
REQ-030 The shared package SHALL hold the state enum typedef and the default STAGES, HOLD_CYCLES and TIMEOUT_CYCLES constants.
REQ-031 The internal reset SHALL be produced by a sub-module instance of the existing reset_synchroniser (clk, async_reset -> sync_reset).

Verification
REQ-032 async_reset pulse, then all stage_ready tied 1 -> stage_reset[0] falls 2+16 cycles after deassertion, stage_reset[1] 17 cycles later, stage_reset[2] 17 cycles after that, seq_done=1 one cycle after.
REQ-033 stage_ready[2] held high from the start, others normal -> stage_reset[2] still released last and not before stage 1 is acknowledged.
REQ-034 sw_reset_req pulsed in GAP after stage 0 is released -> all stage_reset bits=1 next edge, active_stage=0 and the sequence restarts from ASSERT.
REQ-035 RST_SEQ_TIMEOUT_EN defined and stage_ready[1] held 0 -> timeout_err=1 exactly 1024 cycles after stage_reset[1] falls, all resets high; then sw_reset_req -> timeout_err=0.
REQ-036 async_reset asserted while in WAIT -> outputs at reset values with no clock edge; release -> full sequence repeats.
